// File: rtl/carry_propagate_adder_pipe.sv
// Segmented carry-propagate adder: resolves a redundant (C, S) pair into a binary sum,
// one SEG_LEN-bit segment per pipeline stage, with a global-enable valid/ready pipeline.
module carry_propagate_adder_pipe #(
  parameter int BIT_LEN = 16,
  parameter int SEG_LEN = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] C,
  input  logic [BIT_LEN-1:0] S,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN-1:0] out_sum,
  output logic               carry_out
);

  localparam int NUM_SEGS = BIT_LEN / SEG_LEN;

  generate
    if (SEG_LEN < 1 || (BIT_LEN % SEG_LEN) != 0) begin : g_bad_seg
      $error("carry_propagate_adder_pipe: BIT_LEN must be a multiple of SEG_LEN");
    end
  endgenerate

  // One segment add; the extra MSB is the carry into the next stage.
  function automatic logic [SEG_LEN:0] seg_add(input logic [SEG_LEN-1:0] a,
                                               input logic [SEG_LEN-1:0] b,
                                               input logic               ci);
    return {1'b0, a} + {1'b0, b} + {{SEG_LEN{1'b0}}, ci};
  endfunction

  // Slices enter from the top, so after NUM_SEGS stages slice 0 sits at bit 0.
  function automatic logic [BIT_LEN-1:0] shift_in(input logic [SEG_LEN-1:0] slice,
                                                   input logic [BIT_LEN-1:0] prev);
    logic [BIT_LEN+SEG_LEN-1:0] cat;
    cat = {slice, prev};
    return cat[BIT_LEN+SEG_LEN-1:SEG_LEN];
  endfunction

  logic               w_en;
  logic               w_accept;

  logic [BIT_LEN-1:0] r_c_p   [NUM_SEGS];
  logic [BIT_LEN-1:0] r_s_p   [NUM_SEGS];
  logic [BIT_LEN-1:0] r_sum_p [NUM_SEGS];
  logic               r_cy_p  [NUM_SEGS];
  logic               r_vld_p [NUM_SEGS];

  logic [BIT_LEN-1:0] w_c_in   [NUM_SEGS];
  logic [BIT_LEN-1:0] w_s_in   [NUM_SEGS];
  logic [BIT_LEN-1:0] w_sum_in [NUM_SEGS];
  logic               w_cy_in  [NUM_SEGS];
  logic [SEG_LEN:0]   w_add    [NUM_SEGS];

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;
  assign w_accept = in_valid && w_en;

  // Operands are zeroed on bubbles so idle C/S never reach the output registers.
  always_comb begin
    w_c_in[0]   = w_accept ? C : '0;
    w_s_in[0]   = w_accept ? S : '0;
    w_sum_in[0] = '0;
    w_cy_in[0]  = 1'b0;
    for (int k = 1; k < NUM_SEGS; k++) begin
      w_c_in[k]   = r_c_p[k-1];
      w_s_in[k]   = r_s_p[k-1];
      w_sum_in[k] = r_sum_p[k-1];
      w_cy_in[k]  = r_cy_p[k-1];
    end
    for (int k = 0; k < NUM_SEGS; k++) begin
      w_add[k] = seg_add(w_c_in[k][SEG_LEN-1:0], w_s_in[k][SEG_LEN-1:0], w_cy_in[k]);
    end
  end

  // Stage boundary: pending operands shift down by one segment, the new slice shifts in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_SEGS; k++) begin
        r_c_p[k]   <= '0;
        r_s_p[k]   <= '0;
        r_sum_p[k] <= '0;
        r_cy_p[k]  <= 1'b0;
        r_vld_p[k] <= 1'b0;
      end
    end else if (w_en) begin
      r_vld_p[0] <= w_accept;
      for (int k = 1; k < NUM_SEGS; k++) begin
        r_vld_p[k] <= r_vld_p[k-1];
      end
      for (int k = 0; k < NUM_SEGS; k++) begin
        r_c_p[k]   <= w_c_in[k] >> SEG_LEN;
        r_s_p[k]   <= w_s_in[k] >> SEG_LEN;
        r_sum_p[k] <= shift_in(w_add[k][SEG_LEN-1:0], w_sum_in[k]);
        r_cy_p[k]  <= w_add[k][SEG_LEN];
      end
    end
  end

  assign out_valid = r_vld_p[NUM_SEGS-1];
  assign out_sum   = r_sum_p[NUM_SEGS-1];
  assign carry_out = r_cy_p[NUM_SEGS-1];

endmodule

// File: tb/tb_carry_propagate_adder_pipe.sv
// Scoreboard bench for carry_propagate_adder_pipe: directed corner cases plus a
// randomized valid/ready regression checked against plain (BIT_LEN+1)-bit addition.
module tb_carry_propagate_adder_pipe;

  localparam int BL = 16;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [BL-1:0] C = '0;
  logic [BL-1:0] S = '0;
  logic          in_ready;
  logic          out_valid;
  logic [BL-1:0] out_sum;
  logic          carry_out;

  carry_propagate_adder_pipe #(.BIT_LEN(BL), .SEG_LEN(SL)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .C         (C),
    .S         (S),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  logic [BL:0] sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        prev_stall = 1'b0;
  logic [BL:0] prev_res = '0;

  task automatic chk(input string name, input logic [BL:0] got, input logic [BL:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: the exact sum of every accepted pair, in acceptance order.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) sb.push_back({1'b0, C} + {1'b0, S});
      chk("in_ready", 17'(in_ready), 17'(!out_valid || out_ready));
      if (prev_stall) begin
        chk("stall_valid", 17'(out_valid), 17'd1);
        chk("stall_hold", {carry_out, out_sum}, prev_res);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got %h expected none", {carry_out, out_sum});
        end else begin
          chk("result", {carry_out, out_sum}, sb.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = {carry_out, out_sum};
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high.
  task automatic send(input logic [BL-1:0] c, input logic [BL-1:0] s);
    int w;
    w = 0;
    in_valid = 1'b1;
    C = c;
    S = s;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    C = 16'($urandom);
    S = 16'($urandom);
  endtask

  task automatic measure_latency(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk(name, 17'(n), 17'd4);
    @(negedge clk);
    chk({name, "_single"}, 17'(out_valid), 17'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 17'(out_valid), 17'd0);
    chk("reset_out", {carry_out, out_sum}, 17'd0);
    chk("reset_in_ready", 17'(in_ready), 17'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Full overflow and exact latency
    send(16'h0001, 16'hFFFF);
    idle();
    measure_latency("latency_overflow");

    // Carry rippling across segment boundaries
    send(16'h0FFF, 16'h0001);
    send(16'h8000, 16'h8000);
    idle();
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;

    // Back-to-back results on consecutive cycles
    send(16'h0001, 16'h0002);
    send(16'h00F0, 16'h0010);
    send(16'h7FFF, 16'h0001);
    idle();
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    repeat (2) begin
      @(negedge clk);
      chk("b2b_consecutive", 17'(out_valid), 17'd1);
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;

    // Backpressure: fill, stall three cycles, then drain one per cycle
    out_ready = 1'b0;
    send(16'h1234, 16'h1111);
    send(16'hFFFF, 16'hFFFF);
    send(16'h0F0F, 16'hF0F1);
    send(16'hABCD, 16'h0000);
    idle();
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 17'(in_ready), 17'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_drain", 17'(out_valid), 17'd1);
    end
    @(negedge clk);
    chk("bp_empty", 17'(sb.size()), 17'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset with results in flight
    out_ready = 1'b0;
    send(16'h4444, 16'h3333);
    send(16'h5555, 16'h2222);
    idle();
    repeat (2) @(posedge clk);
    #3;
    chk("pre_reset_valid", 17'(out_valid), 17'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_valid", 17'(out_valid), 17'd0);
    chk("async_reset_out", {carry_out, out_sum}, 17'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_reset_quiet", 17'(out_valid), 17'd0);
    end
    @(posedge clk);
    #1;
    send(16'h9999, 16'h6667);
    idle();
    measure_latency("latency_after_reset");
    @(posedge clk);
    #1;

    // Randomized regression with random valid and backpressure
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       begin C = 16'hFFFF; S = 16'($urandom_range(0, 2)); end
        1:       begin C = 16'h8000; S = 16'h8000; end
        default: begin C = 16'($urandom); S = 16'($urandom); end
      endcase
      @(posedge clk);
      #1;
    end
    idle();
    out_ready = 1'b1;
    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("random_drained", 17'(sb.size()), 17'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
